vending_machine_multi: RTL
==========================

# vending_machine_multi

Parametrised multi-product vending controller. It is the next-generation successor to the single-product coin-count FSM. It accepts edge-qualified coins into a saturating credit register and vends from NUM_ITEMS products with per-item price and stock. Change and refunds go out through a valid/ack handshake. It sits between the coin-acceptor/keypad front end and the dispense/change-return actuators.

## Interface
- NUM_ITEMS, 4: number of products; IDX_W = max(1, clog2(NUM_ITEMS)).
- CREDIT_W, 8: width of credit, price and change values.
- PRICES, {8'd30, 8'd40, 8'd15, 8'd25}: packed NUM_ITEMS*CREDIT_W; item i at bits [i*CREDIT_W +: CREDIT_W].
- COIN1_VAL / COIN2_VAL / COIN3_VAL, 5 / 10 / 20: credit values for coin codes 01 / 10 / 11.
- MAX_CREDIT, 100: credit ceiling; must be < 2^CREDIT_W.
- STOCK_W, 4 / STOCK_INIT, 2: stock counter width and reset/restock value.
- TIMEOUT, 64: idle cycles in COLLECT before auto-refund; 0 disables.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- coin  in  2  coin code; 00 = none.
- req  in  1  purchase request, sampled each cycle.
- sel  in  IDX_W  item requested, valid with req.
- cancel  in  1  refund request.
- restock  in  1  set stock[sel] to STOCK_INIT; honoured only in IDLE.
- chg_ack  in  1  change actuator accepts the current change value.
- disp  out  1  one-cycle vend pulse.
- disp_item  out  IDX_W  item being vended; 0 when disp = 0.
- chg_valid  out  1  change/refund pending.
- change  out  CREDIT_W  amount to return; 0 when chg_valid = 0.
- credit  out  CREDIT_W  current credit.
- soldout  out  NUM_ITEMS  bit i = stock[i] == 0.
- coin_reject  out  1  one-cycle pulse: coin not credited.
- err_funds  out  1  one-cycle pulse: request with insufficient credit.
- err_soldout  out  1  one-cycle pulse: request for an empty item or sel >= NUM_ITEMS.

## Operation
- States: IDLE (credit = 0), COLLECT, VEND, CHANGE.
- **Coin event:** coin != 0 while prev_coin == 0. prev_coin is registered every cycle and resets to 00. A held coin counts once.
- **Coin acceptance in IDLE/COLLECT:** if credit + value <= MAX_CREDIT, credit += value and the state goes to COLLECT. Otherwise the coin is not credited and coin_reject is raised.
- **Coins in VEND/CHANGE:** rejected with coin_reject.
- **Requests in COLLECT (req = 1):**
  - sel out of range or stock = 0: err_soldout, stay in COLLECT.
  - Otherwise credit < price[sel]: err_funds, stay in COLLECT.
  - Otherwise accept: credit -= price[sel], stock[sel] -= 1, latch sel, go to VEND.
- **req in IDLE:** err_funds if the item is in stock, else err_soldout.
- **VEND:** disp = 1 and disp_item = latched sel for exactly one cycle. Next state is CHANGE if credit > 0, else IDLE.
- **CHANGE:** chg_valid = 1 and change = credit, held stable until chg_ack. On the ack edge, credit goes to 0 and the state goes to IDLE.
- **cancel in COLLECT:** go to CHANGE with the full credit (refund). cancel in any other state is ignored.
- **Timeout:** the counter clears on any coin event, req, or cancel, and increments in COLLECT. When it reaches TIMEOUT, the block goes to CHANGE as for cancel.
- **Same-cycle priority in COLLECT:** cancel > req > coin.
  - A coin arriving with an accepted cancel or accepted req is rejected (coin_reject).
  - A coin arriving with a failed req is credited normally.
  - The req check uses the credit from before that coin.
- **Arithmetic:** the subtraction never underflows (the check precedes it). Stock never decrements below 0.

## Timing
- **Reset (async, rst_n low):** state = IDLE; credit = 0; stock = STOCK_INIT for all items; prev_coin = 0; timeout counter = 0. All outputs are 0, except soldout = 0 when STOCK_INIT > 0.
- **Output timing:**
  - State, credit and stock update on the edge that samples the event.
  - All outputs are registered or decoded from registers, so they are visible in the following cycle.
  - coin_reject, err_funds and err_soldout are single-cycle pulses in the cycle after the sampling edge.
- **Vend latency:** req sampled at edge N → disp high for the cycle from N to N+1. chg_valid rises at edge N+1 if credit remains.
- **Change handshake:** chg_ack is ignored while chg_valid = 0. If chg_ack is already high when chg_valid rises, the transfer completes on the next edge (minimum one cycle in CHANGE).
- **Reset mid-operation** discards credit and any pending change. No disp pulse is produced.

## Test plan
- **Exact payment, item 0:** coins 5, 10, 10 each separated by 00, then req sel = 0 → disp for 1 cycle with disp_item = 0; no chg_valid; credit 0; stock[0] = 1.
- **Overpay plus handshake, item 1:** coins 20, 10, then req sel = 1 → disp; chg_valid with change = 15 held 3 cycles until chg_ack; then IDLE.
- **Errors:**
  - 15 credit, req sel = 2 → err_funds; credit stays 15.
  - Vend item 0 twice (stock 2 → 0), then req sel = 0 → err_soldout; soldout[0] = 1.
- **Saturation:** five 20-coins reach credit 100; a sixth coin 20 → coin_reject, credit stays 100. Holding coin = 11 for 5 cycles credits once.
- **Cancel and timeout:**
  - credit 35, cancel → change = 35 refund.
  - Separately, a single coin 10 then 64 quiet cycles → chg_valid with change = 10.
- **Priority and reset:**
  - Same-cycle cancel + coin → refund of the old credit and coin_reject.
  - rst_n low during CHANGE → all outputs 0 immediately; credit 0.

Source files
------------

// File: rtl/vending_machine_multi_if.sv
// Front-end / actuator bundle of the multi-product vending controller.
// The master side is the coin acceptor, keypad and actuators; the slave side is the controller.
interface vending_machine_multi_if #(
    parameter int NUM_ITEMS = 4,
    parameter int CREDIT_W  = 8
);
    localparam int IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

    logic [1:0]          coin;
    logic                req;
    logic [IDX_W-1:0]    sel;
    logic                cancel;
    logic                restock;
    logic                chg_ack;
    logic                disp;
    logic [IDX_W-1:0]    disp_item;
    logic                chg_valid;
    logic [CREDIT_W-1:0] change;
    logic [CREDIT_W-1:0] credit;
    logic [NUM_ITEMS-1:0] soldout;
    logic                coin_reject;
    logic                err_funds;
    logic                err_soldout;

    modport master (
        output coin, req, sel, cancel, restock, chg_ack,
        input  disp, disp_item, chg_valid, change, credit, soldout,
               coin_reject, err_funds, err_soldout
    );

    modport slave (
        input  coin, req, sel, cancel, restock, chg_ack,
        output disp, disp_item, chg_valid, change, credit, soldout,
               coin_reject, err_funds, err_soldout
    );
endinterface

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: edge-qualified coins into a saturating credit,
// per-item price/stock, one-cycle vend pulse and valid/ack change return.
module vending_machine_multi #(
    parameter int                                NUM_ITEMS  = 4,
    parameter int                                CREDIT_W   = 8,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0]     PRICES     = {8'd30, 8'd40, 8'd15, 8'd25},
    parameter int                                COIN1_VAL  = 5,
    parameter int                                COIN2_VAL  = 10,
    parameter int                                COIN3_VAL  = 20,
    parameter int                                MAX_CREDIT = 100,
    parameter int                                STOCK_W    = 4,
    parameter int                                STOCK_INIT = 2,
    parameter int                                TIMEOUT    = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    vending_machine_multi_if.slave  bus
);
    localparam int IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
    localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_VEND    = 2'd2,
        ST_CHANGE  = 2'd3
    } state_t;

    state_t               state_r;
    logic [CREDIT_W-1:0]  credit_r;
    logic [STOCK_W-1:0]   stock_r [NUM_ITEMS];
    logic [1:0]           prev_coin_r;
    logic [TMO_W-1:0]     tmo_r;
    logic                 disp_r;
    logic [IDX_W-1:0]     disp_item_r;
    logic                 chg_valid_r;
    logic [CREDIT_W-1:0]  change_r;
    logic                 coin_reject_r;
    logic                 err_funds_r;
    logic                 err_soldout_r;

    logic                 coin_evt_s;
    logic [CREDIT_W-1:0]  coin_val_s;
    logic [CREDIT_W:0]    sum_s;
    logic                 coin_fits_s;
    logic [STOCK_W-1:0]   item_stock_s;
    logic [CREDIT_W-1:0]  item_price_s;
    logic                 item_avail_s;
    logic                 funds_ok_s;
    logic                 tmo_hit_s;
    logic                 cancel_s;
    logic                 buy_s;
    logic                 coin_blocked_s;
    logic [NUM_ITEMS-1:0] soldout_s;

    // Coin value decode and headroom check against the credit ceiling.
    always_comb begin
        coin_evt_s = (bus.coin != 2'b00) && (prev_coin_r == 2'b00);
        case (bus.coin)
            2'b01:   coin_val_s = CREDIT_W'(COIN1_VAL);
            2'b10:   coin_val_s = CREDIT_W'(COIN2_VAL);
            2'b11:   coin_val_s = CREDIT_W'(COIN3_VAL);
            default: coin_val_s = {CREDIT_W{1'b0}};
        endcase
        sum_s       = {1'b0, credit_r} + {1'b0, coin_val_s};
        coin_fits_s = (sum_s <= (CREDIT_W + 1)'(MAX_CREDIT));
    end

    // Selected item lookup; an out-of-range sel matches nothing and reads as empty.
    always_comb begin
        item_stock_s = {STOCK_W{1'b0}};
        item_price_s = {CREDIT_W{1'b0}};
        for (int i = 0; i < NUM_ITEMS; i++) begin
            item_stock_s = (bus.sel == i[IDX_W-1:0]) ? stock_r[i] : item_stock_s;
            item_price_s = (bus.sel == i[IDX_W-1:0]) ? PRICES[i*CREDIT_W +: CREDIT_W] : item_price_s;
        end
        item_avail_s = (item_stock_s != {STOCK_W{1'b0}});
        funds_ok_s   = (credit_r >= item_price_s);
    end

    // Same-cycle arbitration in COLLECT: cancel beats req beats coin; idle time is lowest.
    always_comb begin
        tmo_hit_s      = (TIMEOUT != 0) && (tmo_r >= TMO_W'(TIMEOUT - 1));
        cancel_s       = (state_r == ST_COLLECT) && bus.cancel;
        buy_s          = (state_r == ST_COLLECT) && !bus.cancel && bus.req &&
                         item_avail_s && funds_ok_s;
        coin_blocked_s = (state_r == ST_VEND) || (state_r == ST_CHANGE) || cancel_s || buy_s;
    end

    // Sold-out flags decoded straight from the stock registers.
    always_comb begin
        soldout_s = {NUM_ITEMS{1'b0}};
        for (int i = 0; i < NUM_ITEMS; i++) begin
            soldout_s[i] = (stock_r[i] == {STOCK_W{1'b0}});
        end
    end

    // Controller FSM with all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            credit_r      <= {CREDIT_W{1'b0}};
            prev_coin_r   <= 2'b00;
            tmo_r         <= {TMO_W{1'b0}};
            disp_r        <= 1'b0;
            disp_item_r   <= {IDX_W{1'b0}};
            chg_valid_r   <= 1'b0;
            change_r      <= {CREDIT_W{1'b0}};
            coin_reject_r <= 1'b0;
            err_funds_r   <= 1'b0;
            err_soldout_r <= 1'b0;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_r[i] <= STOCK_W'(STOCK_INIT);
            end
        end else begin
            prev_coin_r   <= bus.coin;
            disp_r        <= 1'b0;
            disp_item_r   <= {IDX_W{1'b0}};
            coin_reject_r <= 1'b0;
            err_funds_r   <= 1'b0;
            err_soldout_r <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    tmo_r <= {TMO_W{1'b0}};
                    if (bus.req) begin
                        err_funds_r   <= item_avail_s;
                        err_soldout_r <= !item_avail_s;
                    end
                    if (bus.restock) begin
                        for (int i = 0; i < NUM_ITEMS; i++) begin
                            if (bus.sel == i[IDX_W-1:0]) begin
                                stock_r[i] <= STOCK_W'(STOCK_INIT);
                            end
                        end
                    end
                end
                ST_COLLECT: begin
                    if (bus.cancel || bus.req || coin_evt_s || tmo_hit_s) begin
                        tmo_r <= {TMO_W{1'b0}};
                    end else begin
                        tmo_r <= tmo_r + TMO_W'(1);
                    end
                    if (cancel_s || (tmo_hit_s && !bus.req && !coin_evt_s)) begin
                        state_r     <= ST_CHANGE;
                        chg_valid_r <= 1'b1;
                        change_r    <= credit_r;
                    end else if (bus.req) begin
                        if (!item_avail_s) begin
                            err_soldout_r <= 1'b1;
                        end else if (!funds_ok_s) begin
                            err_funds_r <= 1'b1;
                        end else begin
                            credit_r    <= credit_r - item_price_s;
                            state_r     <= ST_VEND;
                            disp_r      <= 1'b1;
                            disp_item_r <= bus.sel;
                            for (int i = 0; i < NUM_ITEMS; i++) begin
                                if (bus.sel == i[IDX_W-1:0]) begin
                                    stock_r[i] <= stock_r[i] - STOCK_W'(1);
                                end
                            end
                        end
                    end
                end
                ST_VEND: begin
                    tmo_r <= {TMO_W{1'b0}};
                    if (credit_r != {CREDIT_W{1'b0}}) begin
                        state_r     <= ST_CHANGE;
                        chg_valid_r <= 1'b1;
                        change_r    <= credit_r;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CHANGE: begin
                    tmo_r <= {TMO_W{1'b0}};
                    if (bus.chg_ack && chg_valid_r) begin
                        state_r     <= ST_IDLE;
                        credit_r    <= {CREDIT_W{1'b0}};
                        chg_valid_r <= 1'b0;
                        change_r    <= {CREDIT_W{1'b0}};
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    credit_r    <= {CREDIT_W{1'b0}};
                    chg_valid_r <= 1'b0;
                    change_r    <= {CREDIT_W{1'b0}};
                end
            endcase

            // A coin is credited only when nothing of higher priority consumed the cycle.
            if (coin_evt_s) begin
                if (coin_blocked_s || !coin_fits_s) begin
                    coin_reject_r <= 1'b1;
                end else begin
                    credit_r <= sum_s[CREDIT_W-1:0];
                    if (state_r == ST_IDLE) begin
                        state_r <= ST_COLLECT;
                    end
                end
            end
        end
    end

    assign bus.disp        = disp_r;
    assign bus.disp_item   = disp_item_r;
    assign bus.chg_valid   = chg_valid_r;
    assign bus.change      = change_r;
    assign bus.credit      = credit_r;
    assign bus.soldout     = soldout_s;
    assign bus.coin_reject = coin_reject_r;
    assign bus.err_funds   = err_funds_r;
    assign bus.err_soldout = err_soldout_r;
endmodule
